// File: rtl/fc_pkg.sv
// Shared types and defaults for the FC neuron scheduler.
package fc_pkg;

  localparam int FC_DATA_W  = 8;
  localparam int FC_N_IN    = 8;
  localparam int FC_N_OUT   = 4;
  localparam int FC_TIMEOUT = 16;

  typedef enum logic [2:0] {
    S_LOAD,
    S_FEED,
    S_FLUSH,
    S_WAIT,
    S_EMIT
  } state_t;

  // Counter/index width for n states; never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_vec_buf.sv
// Input vector store: one write port, one asynchronous read port.
module fc_vec_buf
  import fc_pkg::*;
#(
  parameter int DATA_W = FC_DATA_W,
  parameter int N_IN   = FC_N_IN,
  parameter int K_W    = idx_w(FC_N_IN)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [K_W-1:0]    waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [K_W-1:0]    raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [N_IN-1:0][DATA_W-1:0] mem;

  for (genvar i = 0; i < N_IN; i++) begin : g_ent
    always_ff @(posedge clk)
      if (we && waddr == K_W'(i)) mem[i] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fc_neuron_sched.sv
// Time-shares one serial FC dot-product engine across N_OUT neurons:
// load a vector once, replay it per neuron, collect each result onto a stream.
module fc_neuron_sched
  import fc_pkg::*;
#(
  parameter int DATA_W  = FC_DATA_W,
  parameter int N_IN    = FC_N_IN,
  parameter int N_OUT   = FC_N_OUT,
  parameter int TIMEOUT = FC_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic                      eng_valid,
  output logic [DATA_W-1:0]         eng_data,
  output logic [idx_w(N_OUT)-1:0]   eng_sel,
  output logic                      eng_clr,
  input  logic                      eng_ovalid,
  input  logic [DATA_W-1:0]         eng_odata,
  output logic                      res_valid,
  output logic [DATA_W-1:0]         res_data,
  output logic [idx_w(N_OUT)-1:0]   res_idx,
  input  logic                      res_ready,
  output logic                      done,
  output logic                      err
);

  localparam int IDX_W = idx_w(N_OUT);
  localparam int K_W   = idx_w(N_IN);
  localparam int TO_W  = idx_w(TIMEOUT + 1);

  localparam logic [K_W-1:0]   K_LAST  = K_W'(N_IN - 1);
  localparam logic [IDX_W-1:0] J_LAST  = IDX_W'(N_OUT - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [K_W-1:0]    k;
  logic [IDX_W-1:0]  j;
  logic [TO_W-1:0]   wcnt;
  logic [DATA_W-1:0] rd;
  logic              wr, k_last, j_last, timeout, hs;

  assign wr      = (state == S_LOAD) && in_valid;
  assign k_last  = (k == K_LAST);
  assign j_last  = (j == J_LAST);
  assign timeout = (state == S_WAIT) && !eng_ovalid && (wcnt == TO_LAST);
  assign hs      = (state == S_EMIT) && res_ready;

  // k doubles as write pointer in LOAD and replay pointer in FEED.
  fc_vec_buf #(.DATA_W(DATA_W), .N_IN(N_IN), .K_W(K_W)) u_buf (
    .clk   (clk),
    .we    (wr),
    .waddr (k),
    .wdata (in_data),
    .raddr (k),
    .rdata (rd)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:  if (in_valid && k_last) state_nx = S_FEED;
      S_FEED:  if (k_last) state_nx = S_FLUSH;
      S_FLUSH: state_nx = S_WAIT;
      S_WAIT:  if (eng_ovalid) state_nx = S_EMIT;
               else if (timeout) state_nx = S_LOAD;
      S_EMIT:  if (res_ready) state_nx = j_last ? S_LOAD : S_FEED;
      default: state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_LOAD;
      k        <= '0;
      j        <= '0;
      wcnt     <= '0;
      res_data <= '0;
      res_idx  <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
      eng_clr  <= 1'b0;
    end else begin
      state   <= state_nx;
      done    <= hs && j_last;
      eng_clr <= timeout;
      // Engine output outside WAIT is unexpected; flag it but never use its data.
      if ((eng_ovalid && state != S_WAIT) || timeout) err <= 1'b1;
      case (state)
        S_LOAD: if (in_valid) begin
          k <= k_last ? '0 : k + 1'b1;
          if (k_last) j <= '0;
        end
        S_FEED: k <= k_last ? '0 : k + 1'b1;
        S_WAIT: begin
          if (eng_ovalid) begin
            res_data <= eng_odata;
            res_idx  <= j;
            wcnt     <= '0;
          end else if (timeout) begin
            j    <= '0;
            k    <= '0;
            wcnt <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_EMIT: if (res_ready) j <= j_last ? '0 : j + 1'b1;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_LOAD);
  assign eng_valid = (state == S_FEED);
  assign eng_data  = eng_valid ? rd : '0;
  assign eng_sel   = j;
  assign res_valid = (state == S_EMIT);

endmodule

// File: tb/tb_fc_neuron_sched.sv
// Directed/random bench for fc_neuron_sched with a behavioural FC engine model.
module tb_fc_neuron_sched;

  localparam int DATA_W = 8;
  localparam int N_IN   = 8;
  localparam int N_OUT  = 4;
  localparam int PER    = N_IN + 3;

  typedef int vec_t [N_IN];

  logic       clk = 1'b0, rst = 1'b1;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] in_data = '0;
  logic       eng_valid, eng_clr, eng_ovalid;
  logic [7:0] eng_data, eng_odata, res_data;
  logic [1:0] eng_sel, res_idx;
  logic       res_valid, res_ready = 1'b1, done, err;

  int tests = 0, fails = 0, cyc = 0;
  int hang_sel = -1;
  logic stray = 1'b0;

  int rq_data[$], rq_idx[$], rq_cyc[$], done_cyc[$];

  fc_neuron_sched #(.DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .eng_valid(eng_valid), .eng_data(eng_data), .eng_sel(eng_sel), .eng_clr(eng_clr),
    .eng_ovalid(eng_ovalid), .eng_odata(eng_odata), .res_valid(res_valid),
    .res_data(res_data), .res_idx(res_idx), .res_ready(res_ready), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int sat8(input int a);
    int v;
    v = a >>> 4;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  // Expected neuron output: Q4.4 dot product with weight 16*(j+1), bias 0.
  function automatic int ref_res(input vec_t v, input int j);
    int s = 0;
    for (int i = 0; i < N_IN; i++) s += v[i] * 16 * (j + 1);
    return sat8(s);
  endfunction

  // Serial engine: accumulates while valid; one idle cycle registers the result.
  int         acc = 0;
  logic       pend = 1'b0, m_ovalid = 1'b0;
  logic [7:0] m_odata = '0;
  always @(posedge clk) begin
    if (rst || eng_clr) begin
      acc <= 0; pend <= 1'b0; m_ovalid <= 1'b0; m_odata <= '0;
    end else if (eng_valid) begin
      acc      <= acc + int'($signed(eng_data)) * 16 * (int'(eng_sel) + 1);
      pend     <= 1'b1;
      m_ovalid <= 1'b0;
    end else if (pend) begin
      m_ovalid <= (int'(eng_sel) != hang_sel);
      m_odata  <= 8'(sat8(acc));
      acc      <= 0;
      pend     <= 1'b0;
    end else begin
      m_ovalid <= 1'b0;
    end
  end
  assign eng_ovalid = m_ovalid | stray;
  assign eng_odata  = m_odata;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && res_valid && res_ready) begin
      rq_data.push_back(int'($signed(res_data)));
      rq_idx.push_back(int'(res_idx));
      rq_cyc.push_back(cyc);
    end
    if (!rst && done) done_cyc.push_back(cyc);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input vec_t v, input bit gaps);
    for (int i = 0; i < N_IN; i++) begin
      if (gaps && (i % 2 == 1)) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = 8'(v[i]);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, input int n, input int budget);
    for (int c = 0; c < budget && rq_data.size() < n; c++) tick();
    chk(tag, rq_data.size(), n);
  endtask

  task automatic check_res(input string tag, input vec_t v, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      if (base + i < rq_data.size()) begin
        chk({tag, "_data"}, rq_data[base + i], ref_res(v, i));
        chk({tag, "_idx"}, rq_idx[base + i], i);
      end
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < N_IN; i++) v[i] = int'($urandom_range(0, 15)) - 8;
    return v;
  endfunction

  initial begin
    vec_t twos, v;
    int base, nd;
    for (int i = 0; i < N_IN; i++) twos[i] = 2;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_eng_valid", int'(eng_valid), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_eng_clr", int'(eng_clr), 0);

    // 1: nominal, 8 x 2 -> 16,32,48,64 at N_IN+3 spacing, done one cycle after last
    base = rq_data.size();
    nd   = done_cyc.size();
    load_vec(twos, 1'b0);
    wait_res("t1_count", base + N_OUT, 200);
    tick(); tick();
    check_res("t1", twos, base, N_OUT);
    chk("t1_val0", rq_data[base], 16);
    chk("t1_val3", rq_data[base + 3], 64);
    for (int i = 1; i < N_OUT; i++)
      chk("t1_spacing", rq_cyc[base + i] - rq_cyc[base + i - 1], PER);
    chk("t1_done_count", done_cyc.size() - nd, 1);
    if (done_cyc.size() > nd)
      chk("t1_done_cycle", done_cyc[nd], rq_cyc[base + N_OUT - 1] + 1);
    chk("t1_in_ready", int'(in_ready), 1);
    chk("t1_err", int'(err), 0);

    // 2: backpressure on neuron 1
    v = rand_vec();
    base = rq_data.size();
    load_vec(v, 1'b0);
    wait_res("t2_first", base + 1, 100);
    res_ready = 1'b0;
    for (int c = 0; c < 50 && !res_valid; c++) tick();
    chk("t2_res_valid", int'(res_valid), 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t2_hold_valid", int'(res_valid), 1);
      chk("t2_hold_data", int'($signed(res_data)), ref_res(v, 1));
      chk("t2_hold_idx", int'(res_idx), 1);
      chk("t2_eng_idle", int'(eng_valid), 0);
    end
    res_ready = 1'b1;
    wait_res("t2_count", base + N_OUT, 200);
    check_res("t2", v, base, N_OUT);

    // 3: gapped input, extra samples during FEED are ignored
    tick();
    v = rand_vec();
    base = rq_data.size();
    load_vec(v, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h7f;
    for (int c = 0; c < 5; c++) begin
      chk("t3_in_ready_low", int'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;
    wait_res("t3_count", base + N_OUT, 200);
    check_res("t3", v, base, N_OUT);

    // 4: engine hang on neuron 2 -> timeout abort
    tick();
    hang_sel = 2;
    base = rq_data.size();
    load_vec(twos, 1'b0);
    for (int c = 0; c < 200 && !err; c++) tick();
    chk("t4_err", int'(err), 1);
    chk("t4_eng_clr", int'(eng_clr), 1);
    chk("t4_in_ready", int'(in_ready), 1);
    tick();
    chk("t4_eng_clr_pulse", int'(eng_clr), 0);
    for (int c = 0; c < 30; c++) tick();
    chk("t4_res_count", rq_data.size() - base, 2);
    check_res("t4", twos, base, 2);
    chk("t4_res_valid", int'(res_valid), 0);
    hang_sel = -1;

    // 5: reset during FEED of neuron 1
    load_vec(twos, 1'b0);
    for (int c = 0; c < 100 && !(eng_valid && eng_sel == 2'd1); c++) tick();
    chk("t5_feed1", int'(eng_valid && eng_sel == 2'd1), 1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_in_ready", int'(in_ready), 1);
    chk("t5_res_valid", int'(res_valid), 0);
    chk("t5_err", int'(err), 0);
    chk("t5_eng_valid", int'(eng_valid), 0);
    base = rq_data.size();
    load_vec(twos, 1'b0);
    wait_res("t5_count", base + N_OUT, 200);
    check_res("t5", twos, base, N_OUT);

    // 6: stray engine pulse during LOAD sets err; processing continues
    tick();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    chk("t6_err", int'(err), 1);
    v = rand_vec();
    base = rq_data.size();
    load_vec(v, 1'b0);
    wait_res("t6_count", base + N_OUT, 200);
    check_res("t6", v, base, N_OUT);
    chk("t6_err_sticky", int'(err), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
